vga_renderer: RTL and testbench

Downstream video stage of the pong datapath. Consumes the game-state outputs of the game-logic block (pad centres, ball position) and produces 640x480@60 Hz VGA sync and 3-bit colour. It free-runs its own raster counters, snapshots game state once per frame at the start of vertical blanking so that no frame shows mixed old and new state, and rasterises pads, ball and centre net by per-pixel comparison.

---
 rtl/vga_renderer_pkg.sv | 48 ++++
 rtl/vga_renderer_if.sv | 22 ++
 rtl/vga_renderer_timing.sv | 52 +++++
 rtl/vga_renderer.sv | 111 +++++++++++
 tb/tb_vga_renderer.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_renderer_pkg.sv
// Shared pong video constants, game-state snapshot type and pad row test.
// Pure declarations: no logic, no latency, no flow control.
package vga_renderer_pkg;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int PAD_WIDTH     = 8;
  localparam int PAD_HEIGHT    = 34;
  localparam int PAD_DISTANCE  = 20;

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [2:0] RGB_BALL = 3'b110;
  localparam logic [2:0] RGB_PAD  = 3'b111;
  localparam logic [2:0] RGB_NET  = 3'b010;
  localparam logic [2:0] RGB_BG   = 3'b000;

  typedef struct packed {
    logic [9:0] pad_left;
    logic [9:0] pad_right;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
  } game_state_t;

  localparam game_state_t SNAP_RESET = '{
    pad_left:  10'(SCREEN_HEIGHT / 2),
    pad_right: 10'(SCREEN_HEIGHT / 2),
    ball_x:    10'(SCREEN_WIDTH / 2),
    ball_y:    9'(SCREEN_HEIGHT / 2)
  };

  // Lower bound is written as y+H/2 >= pad so pads near y=0 never wrap.
  function automatic logic pad_row_hit(input logic [10:0] y, input logic [9:0] pad);
    logic [10:0] p;
    p = {1'b0, pad};
    return (y + 11'(PAD_HEIGHT / 2) >= p) && (y <= p + 11'(PAD_HEIGHT / 2));
  endfunction

endpackage

// File: rtl/vga_renderer_if.sv
// Game-state inputs and video outputs of the pong renderer.
// master = game/monitor side, slave = renderer side.
interface vga_renderer_if;
  logic [9:0] pad_left;
  logic [9:0] pad_right;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic       hsync;
  logic       vsync;
  logic [2:0] rgb;
  logic       frame_tick;

  modport master (
    output pad_left, pad_right, ball_x, ball_y,
    input  hsync, vsync, rgb, frame_tick
  );

  modport slave (
    input  pad_left, pad_right, ball_x, ball_y,
    output hsync, vsync, rgb, frame_tick
  );
endinterface

// File: rtl/vga_renderer_timing.sv
// 640x480 raster timing: pixel divider, hc/vc counters, visible flag, raw syncs.
// Outputs are combinational from the counters; free-running, no backpressure.
module vga_timing
  import vga_renderer_pkg::*;
#(
  parameter int PIX_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] hc,
  output logic [9:0] vc,
  output logic       visible,
  output logic       hsync_raw,
  output logic       vsync_raw
);

  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  logic [DW-1:0] div;

  assign pix_en = (div == DW'(PIX_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
    end else if (pix_en) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hc <= '0;
      vc <= '0;
    end else if (pix_en) begin
      if (hc == 10'(H_TOTAL - 1)) begin
        hc <= '0;
        vc <= (vc == 10'(V_TOTAL - 1)) ? 10'd0 : vc + 10'd1;
      end else begin
        hc <= hc + 10'd1;
      end
    end
  end

  assign visible   = (hc < 10'(H_VISIBLE)) && (vc < 10'(V_VISIBLE));
  assign hsync_raw = !((hc >= 10'(H_VISIBLE + H_FP)) && (hc < 10'(H_VISIBLE + H_FP + H_SYNC)));
  assign vsync_raw = !((vc >= 10'(V_VISIBLE + V_FP)) && (vc < 10'(V_VISIBLE + V_FP + V_SYNC)));

endmodule

// File: rtl/vga_renderer.sv
// Pong video stage: per-frame game-state snapshot, per-pixel shape compare, registered sync/rgb.
// Outputs lag the raster counters by one pixel period; free-running, inputs sampled once per frame.
module vga_renderer
  import vga_renderer_pkg::*;
#(
  parameter int PIX_DIV = 2,
  parameter int BALL_R  = 2
) (
  input  logic           clk,
  input  logic           rst,
  vga_renderer_if.slave  vif
);

  localparam logic signed [10:0] R_POS = 11'(BALL_R);
  localparam logic signed [10:0] R_NEG = 11'(-BALL_R);
  localparam logic [10:0] LPAD_X0 = 11'(PAD_DISTANCE);
  localparam logic [10:0] LPAD_X1 = 11'(PAD_DISTANCE + PAD_WIDTH - 1);
  localparam logic [10:0] RPAD_X0 = 11'(SCREEN_WIDTH - PAD_DISTANCE - PAD_WIDTH);
  localparam logic [10:0] RPAD_X1 = 11'(SCREEN_WIDTH - PAD_DISTANCE - 1);
  localparam logic [9:0]  NET_X0  = 10'(SCREEN_WIDTH / 2 - 1);
  localparam logic [9:0]  NET_X1  = 10'(SCREEN_WIDTH / 2);

  logic       pix_en;
  logic       visible;
  logic       hsync_raw;
  logic       vsync_raw;
  logic [9:0] hc;
  logic [9:0] vc;

  vga_timing #(.PIX_DIV(PIX_DIV)) u_timing (
    .clk       (clk),
    .rst       (rst),
    .pix_en    (pix_en),
    .hc        (hc),
    .vc        (vc),
    .visible   (visible),
    .hsync_raw (hsync_raw),
    .vsync_raw (vsync_raw)
  );

  // Snapshot lands in vertical blanking, so every visible frame sees one consistent state.
  game_state_t snap;
  logic        snap_en;
  logic        frame_tick_q;

  assign snap_en = pix_en && (hc == 10'd0) && (vc == 10'(V_VISIBLE));

  always_ff @(posedge clk) begin
    if (rst) begin
      snap         <= SNAP_RESET;
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= snap_en;
      if (snap_en) begin
        snap <= '{pad_left: vif.pad_left, pad_right: vif.pad_right,
                  ball_x: vif.ball_x, ball_y: vif.ball_y};
      end
    end
  end

  logic [10:0]        x;
  logic [10:0]        y;
  logic signed [10:0] dx;
  logic signed [10:0] dy;
  logic               hit_ball;
  logic               hit_pad;
  logic               hit_net;
  logic [2:0]         colour;

  // Game y runs bottom-up; blank rows give a wrapped y that the visible mask discards.
  always_comb begin
    x        = {1'b0, hc};
    y        = 11'(V_VISIBLE - 1) - {1'b0, vc};
    dx       = $signed(x) - $signed({1'b0, snap.ball_x});
    dy       = $signed(y) - $signed({2'b00, snap.ball_y});
    hit_ball = (dx >= R_NEG) && (dx <= R_POS) && (dy >= R_NEG) && (dy <= R_POS);
    hit_pad  = ((x >= LPAD_X0) && (x <= LPAD_X1) && pad_row_hit(y, snap.pad_left)) ||
               ((x >= RPAD_X0) && (x <= RPAD_X1) && pad_row_hit(y, snap.pad_right));
    hit_net  = ((hc == NET_X0) || (hc == NET_X1)) && !vc[4];
    colour   = RGB_BG;
    if (hit_ball) begin
      colour = RGB_BALL;
    end else if (hit_pad) begin
      colour = RGB_PAD;
    end else if (hit_net) begin
      colour = RGB_NET;
    end
  end

  logic       hsync_q;
  logic       vsync_q;
  logic [2:0] rgb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= RGB_BG;
    end else if (pix_en) begin
      hsync_q <= hsync_raw;
      vsync_q <= vsync_raw;
      rgb_q   <= visible ? colour : RGB_BG;
    end
  end

  assign vif.hsync      = hsync_q;
  assign vif.vsync      = vsync_q;
  assign vif.rgb        = rgb_q;
  assign vif.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_renderer.sv
// Bench for vga_renderer: two instances (1 and 3 clocks per pixel) compared every clock
// against a pixel-index model of the raster, snapshot and shape rules.
module tb_vga_renderer;
  import vga_renderer_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] g_pl = 10'd240;
  logic [9:0] g_pr = 10'd240;
  logic [9:0] g_bx = 10'd320;
  logic [8:0] g_by = 9'd240;
  logic       hold = 1'b0;

  int n = 0;
  int s_pl = 240, s_pr = 240, s_bx = 320, s_by = 240;
  int checks = 0;
  int errors = 0;
  int hs_low = 0, vs_low = 0, ft_cnt = 0;

  always #5 clk = ~clk;

  vga_renderer_if vif1 ();
  vga_renderer_if vif2 ();

  assign vif1.pad_left  = g_pl;
  assign vif1.pad_right = g_pr;
  assign vif1.ball_x    = g_bx;
  assign vif1.ball_y    = g_by;
  assign vif2.pad_left  = g_pl;
  assign vif2.pad_right = g_pr;
  assign vif2.ball_x    = g_bx;
  assign vif2.ball_y    = g_by;

  vga_renderer #(.PIX_DIV(1), .BALL_R(2)) dut1 (.clk(clk), .rst(rst), .vif(vif1.slave));
  vga_renderer #(.PIX_DIV(3), .BALL_R(2)) dut2 (.clk(clk), .rst(rst), .vif(vif2.slave));

  logic [5:0] o1, o2;
  assign o1 = {vif1.frame_tick, vif1.hsync, vif1.vsync, vif1.rgb};
  assign o2 = {vif2.frame_tick, vif2.hsync, vif2.vsync, vif2.rgb};

  // Edge count since reset release, and the state dut1 should have snapshotted.
  always @(posedge clk) begin
    if (rst) begin
      n    <= 0;
      s_pl <= 240; s_pr <= 240; s_bx <= 320; s_by <= 240;
    end else begin
      if (n % 420000 == 384000) begin
        s_pl <= int'(g_pl); s_pr <= int'(g_pr); s_bx <= int'(g_bx); s_by <= int'(g_by);
      end
      n <= n + 1;
    end
  end

  // Expected {frame_tick,hsync,vsync,rgb} after n post-reset edges with p clocks per pixel.
  function automatic logic [5:0] ref_out(input int cnt, input int p, input int pl, input int pr,
                                         input int bx, input int by);
    int i, hc, vc, x, y;
    logic ft, hs, vs;
    logic [2:0] c;
    ft = (cnt > 0) && (cnt % p == 0) && ((cnt / p - 1) % 420000 == 384000);
    if (cnt / p == 0) return {ft, 1'b1, 1'b1, 3'b000};
    i  = (cnt / p - 1) % 420000;
    hc = i % 800;
    vc = i / 800;
    hs = !(hc >= 656 && hc <= 751);
    vs = !(vc >= 490 && vc <= 491);
    c  = 3'b000;
    if (hc < 640 && vc < 480) begin
      x = hc;
      y = 479 - vc;
      if ((x == 319 || x == 320) && ((vc / 16) % 2 == 0)) c = 3'b010;
      if ((x >= PAD_DISTANCE && x < PAD_DISTANCE + PAD_WIDTH &&
           y >= pl - PAD_HEIGHT / 2 && y <= pl + PAD_HEIGHT / 2) ||
          (x >= SCREEN_WIDTH - PAD_DISTANCE - PAD_WIDTH && x < SCREEN_WIDTH - PAD_DISTANCE &&
           y >= pr - PAD_HEIGHT / 2 && y <= pr + PAD_HEIGHT / 2)) c = 3'b111;
      if (x - bx <= 2 && bx - x <= 2 && y - by <= 2 && by - y <= 2) c = 3'b110;
    end
    return {ft, hs, vs, c};
  endfunction

  task automatic churn();
    if (!hold && $urandom_range(0, 3) == 0) begin
      case ($urandom_range(0, 3))
        0: g_pl = 10'($urandom_range(0, 1023));
        1: g_pr = 10'($urandom_range(0, 1023));
        2: g_bx = 10'($urandom_range(0, 1023));
        default: g_by = 9'($urandom_range(0, 511));
      endcase
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks += 2;
      if (o1 !== 6'b011000) begin
        errors++; $display("FAIL reset_dut1 cycle %0d: got %b want 011000", k, o1);
      end
      if (o2 !== 6'b011000) begin
        errors++; $display("FAIL reset_dut2 cycle %0d: got %b want 011000", k, o2);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_raster();
    logic [5:0] e1, e2;
    while (n < 383000) begin
      @(negedge clk);
      e1 = ref_out(n, 1, s_pl, s_pr, s_bx, s_by);
      e2 = ref_out(n, 3, 240, 240, 320, 240);
      checks += 2;
      if (o1 !== e1) begin
        errors++; if (errors < 20) $display("FAIL raster_dut1 n=%0d: got %b want %b", n, o1, e1);
      end
      if (o2 !== e2) begin
        errors++; if (errors < 20) $display("FAIL raster_dut2 n=%0d: got %b want %b", n, o2, e2);
      end
      if (!vif1.hsync) hs_low++;
      if (!vif1.vsync) vs_low++;
      if (vif1.frame_tick) ft_cnt++;
      if (n == 200 * 800) g_pl = 10'd100;
      churn();
    end
  endtask

  task automatic test_snapshot();
    logic [5:0] e1, e2;
    hold = 1'b1;
    g_pl = 10'd10; g_pr = 10'd0; g_bx = 10'd619; g_by = 9'd0;
    while (n < 420000) begin
      @(negedge clk);
      e1 = ref_out(n, 1, s_pl, s_pr, s_bx, s_by);
      e2 = ref_out(n, 3, 240, 240, 320, 240);
      checks += 2;
      if (o1 !== e1) begin
        errors++; if (errors < 20) $display("FAIL snapshot_dut1 n=%0d: got %b want %b", n, o1, e1);
      end
      if (o2 !== e2) begin
        errors++; if (errors < 20) $display("FAIL snapshot_dut2 n=%0d: got %b want %b", n, o2, e2);
      end
      if (!vif1.hsync) hs_low++;
      if (!vif1.vsync) vs_low++;
      if (vif1.frame_tick) ft_cnt++;
      if (n > 384002) hold = 1'b0;
      churn();
    end
    checks += 3;
    if (hs_low != 96 * 525) begin
      errors++; $display("FAIL hsync_low_count: got %0d want %0d", hs_low, 96 * 525);
    end
    if (vs_low != 1600) begin
      errors++; $display("FAIL vsync_low_count: got %0d want 1600", vs_low);
    end
    if (ft_cnt != 1) begin
      errors++; $display("FAIL frame_tick_count: got %0d want 1", ft_cnt);
    end
  endtask

  task automatic test_clip_overlap();
    logic [5:0] e1, e2;
    int c110 = 0, c111 = 0, top = 0, vc;
    while (n < 420000 + 479 * 800 + 700) begin
      @(negedge clk);
      e1 = ref_out(n, 1, s_pl, s_pr, s_bx, s_by);
      e2 = ref_out(n, 3, 240, 240, 320, 240);
      checks += 2;
      if (o1 !== e1) begin
        errors++; if (errors < 20) $display("FAIL clip_dut1 n=%0d: got %b want %b", n, o1, e1);
      end
      if (o2 !== e2) begin
        errors++; if (errors < 20) $display("FAIL clip_dut2 n=%0d: got %b want %b", n, o2, e2);
      end
      vc = (n - 1 - 420000) / 800;
      if (vif1.rgb == 3'b110) c110++;
      if (vif1.rgb == 3'b111) c111++;
      if (vc < 3 && (vif1.rgb == 3'b110 || vif1.rgb == 3'b111)) top++;
      churn();
    end
    checks += 3;
    if (c110 != 15) begin
      errors++; $display("FAIL ball_pixels_clipped: got %0d want 15", c110);
    end
    if (c111 != 224 + 144 - 9) begin
      errors++; $display("FAIL pad_pixels_overlap: got %0d want %0d", c111, 224 + 144 - 9);
    end
    if (top != 0) begin
      errors++; $display("FAIL top_rows_wrap: got %0d coloured want 0", top);
    end
  endtask

  task automatic test_mid_reset();
    logic [5:0] e1, e2;
    int c110 = 0, c111 = 0;
    rst = 1'b1;
    @(negedge clk);
    checks += 2;
    if (o1 !== 6'b011000) begin
      errors++; $display("FAIL mid_reset_dut1: got %b want 011000", o1);
    end
    if (o2 !== 6'b011000) begin
      errors++; $display("FAIL mid_reset_dut2: got %b want 011000", o2);
    end
    rst = 1'b0;
    while (n < 260 * 800) begin
      @(negedge clk);
      e1 = ref_out(n, 1, 240, 240, 320, 240);
      e2 = ref_out(n, 3, 240, 240, 320, 240);
      checks += 2;
      if (o1 !== e1) begin
        errors++; if (errors < 20) $display("FAIL post_reset_dut1 n=%0d: got %b want %b", n, o1, e1);
      end
      if (o2 !== e2) begin
        errors++; if (errors < 20) $display("FAIL post_reset_dut2 n=%0d: got %b want %b", n, o2, e2);
      end
      if (vif1.rgb == 3'b110) c110++;
      if (vif1.rgb == 3'b111) c111++;
      churn();
    end
    checks += 2;
    if (c110 != 25) begin
      errors++; $display("FAIL default_ball_pixels: got %0d want 25", c110);
    end
    if (c111 != 560) begin
      errors++; $display("FAIL default_pad_pixels: got %0d want 560", c111);
    end
  endtask

  initial begin
    test_reset();
    test_raster();
    test_snapshot();
    test_clip_overlap();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
